pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Detects load-use

---
 rtl/pipe_hazard_ctrl_pkg.sv | 51 +++++
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // Sequencer states
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  // Pipeline register controls for one cycle
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } ctrl_t;

  // Everything off: used while reset holds the pipeline frozen
  localparam ctrl_t CTRL_OFF    = 7'b000_0000;
  // Whole pipeline held, MEM/WB gets a bubble so the stalled access never retires twice
  localparam ctrl_t CTRL_FREEZE = 7'b000_0001;

  // Normal-flow controls when memory is not holding the pipe:
  // redirect beats load-use because the ID instruction is squashed anyway.
  function automatic ctrl_t run_ctrl(input logic redirect, input logic load_use);
    ctrl_t c;
    c = '0;
    c.id_ex_write  = 1'b1;
    c.ex_mem_write = 1'b1;
    if (redirect) begin
      c.pc_write    = 1'b1;
      c.if_id_write = 1'b1;
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.id_ex_flush = 1'b1;
    end else begin
      c.pc_write    = 1'b1;
      c.if_id_write = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and the register controls/counters returned to the pipe.
// Latency: wiring only.
// Backpressure: n/a; the controls themselves are the pipeline's stall mechanism.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_ADDR_W-1:0] ID_Rs1;
  logic [REG_ADDR_W-1:0] ID_Rs2;
  logic                  ID_UseRs1;
  logic                  ID_UseRs2;
  logic                  EX_MemRead;
  logic [REG_ADDR_W-1:0] EX_Rd;
  logic                  EX_Redirect;
  logic                  MEM_Req;
  logic                  MEM_Ack;

  logic                  PCWrite;
  logic                  IF_IDWrite;
  logic                  IF_IDFlush;
  logic                  ID_EXWrite;
  logic                  ID_EXFlush;
  logic                  EX_MEMWrite;
  logic                  MEM_WBFlush;
  logic                  mem_err;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  // Pipeline side: presents hazard information, consumes controls
  modport master (
    output ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, EX_MemRead, EX_Rd,
           EX_Redirect, MEM_Req, MEM_Ack,
    input  PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
           EX_MEMWrite, MEM_WBFlush, mem_err, stall_cnt, flush_cnt
  );

  // Sequencer side
  modport slave (
    input  ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, EX_MemRead, EX_Rd,
           EX_Redirect, MEM_Req, MEM_Ack,
    output PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
           EX_MEMWrite, MEM_WBFlush, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics.
// Latency: count visible the cycle after inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step only while below the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirect, data-memory wait.
// Latency: controls are combinational from state + inputs (zero cycles).
// Backpressure: MEM_Req without MEM_Ack freezes every stage until ack, timeout -> sticky ERR.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              load_use;
  logic              mem_busy;
  logic              mem_err;
  logic              stall_inc;
  logic              flush_inc;
  ctrl_t             ctrl;

  // Hazard detection: load result needed by the ID instruction, or memory not yet done
  always_comb begin
    load_use = bus.EX_MemRead && (bus.EX_Rd != REG_X0) &&
               ((bus.ID_UseRs1 && (bus.ID_Rs1 == bus.EX_Rd)) ||
                (bus.ID_UseRs2 && (bus.ID_Rs2 == bus.EX_Rd)));
    mem_busy = bus.MEM_Req && !bus.MEM_Ack;
  end

  // Control decode; reset forces everything off so no stage captures garbage
  always_comb begin
    ctrl    = CTRL_OFF;
    mem_err = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN:      ctrl = mem_busy ? CTRL_FREEZE : run_ctrl(bus.EX_Redirect, load_use);
        // Redirect/load-use were held in the frozen stages and are served on the ack cycle
        ST_MEM_WAIT: ctrl = bus.MEM_Ack ? run_ctrl(bus.EX_Redirect, load_use) : CTRL_FREEZE;
        ST_ERR: begin
          ctrl    = CTRL_FREEZE;
          mem_err = 1'b1;
        end
        default:     ctrl = CTRL_FREEZE;
      endcase
    end
  end

  // Next state and memory wait duration
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.MEM_Ack) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ERR;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // FSM and wait counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Only a served redirect flushes IF/ID, so that flag marks a redirect event
  always_comb begin
    stall_inc = !reset && !ctrl.pc_write;
    flush_inc = ctrl.if_id_flush;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (reset),
    .inc (stall_inc),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (reset),
    .inc (flush_inc),
    .cnt (bus.flush_cnt)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.IF_IDWrite  = ctrl.if_id_write;
  assign bus.IF_IDFlush  = ctrl.if_id_flush;
  assign bus.ID_EXWrite  = ctrl.id_ex_write;
  assign bus.ID_EXFlush  = ctrl.id_ex_flush;
  assign bus.EX_MEMWrite = ctrl.ex_mem_write;
  assign bus.MEM_WBFlush = ctrl.mem_wb_flush;
  assign bus.mem_err     = mem_err;

endmodule
